pong_ball_engine: RTL and testbench
===================================

# pong_ball_engine

Parametrised ball engine for the Pong datapath, replacing the fixed-step ball. It advances the ball once per frame `tick` with a variable speed and reflects off the side walls and both paddles. Paddle hits steer the lateral direction by contact zone and raise the speed every N hits. Misses become per-player score pulses, and a serve state machine re-launches the ball. Outputs feed the pixel renderer and the score counters.

## Interface
- `SIZE`, 10: ball edge length in pixels
- `X_W`, 8: lateral coordinate width
- `Y_W`, 9: travel-axis coordinate width
- `MIN_X` / `MAX_X`, 0 / 239: lateral wall limits
- `MIN_Y` / `MAX_Y`, 30 / 290: goal lines for player 1 / player 2
- `START_X` / `START_Y`, 120 / 160: serve position
- `PADDLE_WIDTH`, 5: paddle depth along y
- `PADDLE_HEIGHT`, 41: paddle length along x
- `MAX_SPEED`, 4: maximum step in pixels per tick on both axes
- `HITS_PER_SPEEDUP`, 4: paddle hits per speed increment
- `SERVE_DELAY`, 60: ticks before an automatic serve
- `clock`, in, 1: clock
- `reset`, in, 1: synchronous, active-high
- `tick`, in, 1: frame-rate movement enable, one-cycle pulse
- `serve`, in, 1: immediate serve request
- `paddle_1_x`, in, X_W: top x of the paddle at the MIN_Y side
- `paddle_2_x`, in, X_W: top x of the paddle at the MAX_Y side
- `ball_x`, out, X_W: ball top-left x, registered
- `ball_y`, out, Y_W: ball top-left y, registered
- `in_play`, out, 1: high in the PLAY state
- `hit`, out, 1: one-cycle pulse on a paddle contact
- `point_p1` / `point_p2`, out, 1: one-cycle pulse when player 1 / player 2 scores
- `speed`, out, 3: current step size, 1..MAX_SPEED

## Operation
- **States:** SERVE_WAIT → PLAY → SCORED → SERVE_WAIT.
- **Reset:**
  - State SERVE_WAIT; ball at (START_X, START_Y).
  - `dir_y` = 1 (+y), `dir_x` = 0 (−x).
  - `speed` = 1; hit and serve counters = 0.
  - All pulses 0; `in_play` = 0.
- **SERVE_WAIT:**
  - Ball is held at START.
  - The serve counter increments per tick.
  - Go to PLAY on `serve`=1, or on the tick that makes the counter equal SERVE_DELAY.
  - The counter clears on exit.
- **PLAY, per tick:** next positions are computed in Y_W+1 / X_W+1 signed-safe arithmetic (no wrap). Each axis moves by `speed` in its direction.
- **Side walls:**
  - If next x ≤ MIN_X, clamp to MIN_X and set `dir_x` = 1.
  - If next x + SIZE ≥ MAX_X, clamp to MAX_X − SIZE and set `dir_x` = 0.
- **Paddle 1** (moving −y):
  - Face F1 = MIN_Y + PADDLE_WIDTH.
  - Contact when current y ≥ F1, next y ≤ F1 and overlap (x + SIZE > paddle_1_x and x < paddle_1_x + PADDLE_HEIGHT).
  - On contact: y clamps to F1, `dir_y` = 1, `hit` pulses.
- **Paddle 2** (moving +y):
  - Face F2 = MAX_Y − PADDLE_WIDTH.
  - Contact when current y + SIZE ≤ F2, next y + SIZE ≥ F2 and overlap with `paddle_2_x`.
  - On contact: y clamps to F2 − SIZE, `dir_y` = 0, `hit` pulses.
- **Contact zone:** the ball centre offset c = x + SIZE/2 − paddle_x sets the lateral direction.
  - c < PADDLE_HEIGHT/3: `dir_x` = 0.
  - c ≥ 2·PADDLE_HEIGHT/3: `dir_x` = 1.
  - Otherwise `dir_x` is unchanged.
  - A side-wall reflection in the same tick takes precedence over the zone rule.
- **Speed-up:**
  - The hit counter increments per hit.
  - When it reaches HITS_PER_SPEEDUP it clears and `speed` increments, saturating at MAX_SPEED.
- **Miss:**
  - Next y ≤ MIN_Y without contact: y clamps to MIN_Y, `point_p2` pulses, go to SCORED.
  - Next y + SIZE ≥ MAX_Y without contact: y clamps to MAX_Y − SIZE, `point_p1` pulses, go to SCORED.
- **SCORED** (one cycle):
  - Ball returns to START; `speed` = 1; hit counter = 0.
  - `dir_y` points toward the conceding player; `dir_x` is kept.
  - Go to SERVE_WAIT.

## Timing
- All outputs are registered. The position update is visible the cycle after the `tick` is sampled.
- `hit` and `point_*` pulses are aligned with the position update that caused them.
- No movement occurs when `tick`=0. `serve` is ignored outside SERVE_WAIT.
- If `serve` and `tick` are both high in SERVE_WAIT, the state goes to PLAY with no movement that cycle.
- `reset` overrides everything in any state, including mid-SCORED.
- Contact and miss on the same side cannot both occur; contact wins.

## Structure
- Shared package `pong_pkg`: state enum (SERVE_WAIT, PLAY, SCORED), default geometry constants, and the speed width.
- Sub-module `pong_ball_collide`: combinational next-position, clamp, reflection and event logic. The engine holds the FSM, counters and registers.

## Test plan
- Reset, then 60 ticks with no `serve` → `in_play` rises after tick 60; ball at (120,160), first move to y=161, x=119.
- Ball at x=2 moving −x at speed 4, tick → x=0, `dir_x`=1; next tick x=4.
- `paddle_1_x`=100, ball at y=36, x=100 (c=5), moving −y at speed 2 → y=35, `hit`=1, `dir_y`=1, `dir_x`=0.
- Four consecutive paddle hits at speed 1 → `speed`=2; 16 further hits at `MAX_SPEED`=4 → remains 4.
- `paddle_2_x`=0, ball at x=200 moving +y → `point_p1` single pulse with y=280; next cycle ball at START, `speed`=1, `dir_y`=1.
- Assert `reset` mid-PLAY at speed 3 → next cycle ball at START, SERVE_WAIT, `speed`=1, no pulses.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, speed width and default geometry for the ball engine
package pong_pkg;
  typedef enum logic [1:0] {SERVE_WAIT, PLAY, SCORED} state_t;
  localparam int SPEED_W = 3;
  localparam int DEF_SIZE = 10;
  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 9;
  localparam int DEF_MIN_X = 0;
  localparam int DEF_MAX_X = 239;
  localparam int DEF_MIN_Y = 30;
  localparam int DEF_MAX_Y = 290;
  localparam int DEF_START_X = 120;
  localparam int DEF_START_Y = 160;
  localparam int DEF_PADDLE_WIDTH = 5;
  localparam int DEF_PADDLE_HEIGHT = 41;
  localparam int DEF_MAX_SPEED = 4;
  localparam int DEF_HITS_PER_SPEEDUP = 4;
  localparam int DEF_SERVE_DELAY = 60;
endpackage

// File: rtl/pong_ball_collide.sv
// pong_ball_collide: one-step ball move with wall clamps, paddle reflection and goal detection
module pong_ball_collide
  import pong_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int MIN_X = DEF_MIN_X,
  parameter int MAX_X = DEF_MAX_X,
  parameter int MIN_Y = DEF_MIN_Y,
  parameter int MAX_Y = DEF_MAX_Y,
  parameter int PADDLE_WIDTH = DEF_PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT
) (
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  input  logic               dir_x,
  input  logic               dir_y,
  input  logic [SPEED_W-1:0] speed,
  input  logic [X_W-1:0]     paddle_1_x,
  input  logic [X_W-1:0]     paddle_2_x,
  output logic [X_W-1:0]     next_x,
  output logic [Y_W-1:0]     next_y,
  output logic               next_dir_x,
  output logic               next_dir_y,
  output logic               hit,
  output logic               point_p1,
  output logic               point_p2
);
  localparam int F1 = MIN_Y + PADDLE_WIDTH;
  localparam int F2 = MAX_Y - PADDLE_WIDTH;
  int sx, sy, sp, nx, ny, px, c;
  logic over, miss, wall_lo, wall_hi;
  // Wide signed arithmetic so under/overflow near the walls never wraps; dir_y picks the paddle ahead.
  always_comb begin
    sx = int'(x);
    sy = int'(y);
    sp = int'(speed);
    nx = dir_x ? sx + sp : sx - sp;
    ny = dir_y ? sy + sp : sy - sp;
    px = dir_y ? int'(paddle_2_x) : int'(paddle_1_x);
    over = sx + SIZE > px && sx < px + PADDLE_HEIGHT;
    c = sx + SIZE / 2 - px;
    hit = dir_y ? (sy + SIZE <= F2 && ny + SIZE >= F2 && over) : (sy >= F1 && ny <= F1 && over);
    miss = !hit && (dir_y ? ny + SIZE >= MAX_Y : ny <= MIN_Y);
    point_p1 = miss && dir_y;
    point_p2 = miss && !dir_y;
    wall_lo = nx <= MIN_X;
    wall_hi = nx + SIZE >= MAX_X;
    next_dir_x = wall_lo ? 1'b1 : wall_hi ? 1'b0 :
                 (hit && c < PADDLE_HEIGHT / 3) ? 1'b0 :
                 (hit && c >= 2 * PADDLE_HEIGHT / 3) ? 1'b1 : dir_x;
    next_x = X_W'(wall_lo ? MIN_X : wall_hi ? MAX_X - SIZE : nx);
    next_dir_y = hit ? !dir_y : dir_y;
    next_y = Y_W'(hit ? (dir_y ? F2 - SIZE : F1) : miss ? (dir_y ? MAX_Y - SIZE : MIN_Y) : ny);
  end
endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: serve FSM, speed-up counters and registered ball state for the Pong datapath
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W,
  parameter int MIN_X = DEF_MIN_X,
  parameter int MAX_X = DEF_MAX_X,
  parameter int MIN_Y = DEF_MIN_Y,
  parameter int MAX_Y = DEF_MAX_Y,
  parameter int START_X = DEF_START_X,
  parameter int START_Y = DEF_START_Y,
  parameter int PADDLE_WIDTH = DEF_PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT = DEF_PADDLE_HEIGHT,
  parameter int MAX_SPEED = DEF_MAX_SPEED,
  parameter int HITS_PER_SPEEDUP = DEF_HITS_PER_SPEEDUP,
  parameter int SERVE_DELAY = DEF_SERVE_DELAY
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic               serve,
  input  logic [X_W-1:0]     paddle_1_x,
  input  logic [X_W-1:0]     paddle_2_x,
  output logic [X_W-1:0]     ball_x,
  output logic [Y_W-1:0]     ball_y,
  output logic               in_play,
  output logic               hit,
  output logic               point_p1,
  output logic               point_p2,
  output logic [SPEED_W-1:0] speed
);
  localparam int HC_W = $clog2(HITS_PER_SPEEDUP + 1);
  localparam int SC_W = $clog2(SERVE_DELAY + 1);
  state_t state_q, state_d;
  logic [X_W-1:0] x_q, x_d, nx;
  logic [Y_W-1:0] y_q, y_d, ny;
  logic dir_x_q, dir_x_d, dir_y_q, dir_y_d, ndx, ndy;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [HC_W-1:0] hits_q, hits_d;
  logic [SC_W-1:0] cnt_q, cnt_d;
  logic hit_q, hit_d, p1_q, p1_d, p2_q, p2_d;
  logic c_hit, c_p1, c_p2, launch, speedup;

  pong_ball_collide #(
    .SIZE(SIZE), .X_W(X_W), .Y_W(Y_W), .MIN_X(MIN_X), .MAX_X(MAX_X),
    .MIN_Y(MIN_Y), .MAX_Y(MAX_Y), .PADDLE_WIDTH(PADDLE_WIDTH), .PADDLE_HEIGHT(PADDLE_HEIGHT)
  ) u_collide (
    .x(x_q), .y(y_q), .dir_x(dir_x_q), .dir_y(dir_y_q), .speed(speed_q),
    .paddle_1_x(paddle_1_x), .paddle_2_x(paddle_2_x),
    .next_x(nx), .next_y(ny), .next_dir_x(ndx), .next_dir_y(ndy),
    .hit(c_hit), .point_p1(c_p1), .point_p2(c_p2)
  );

  assign launch = serve || (tick && cnt_q == SC_W'(SERVE_DELAY - 1));
  assign speedup = hits_q == HC_W'(HITS_PER_SPEEDUP - 1);

  // Next-state: hold at START while waiting, step on tick in PLAY, recentre for one cycle after a goal.
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    speed_d = speed_q;
    hits_d = hits_q;
    cnt_d = cnt_q;
    hit_d = 1'b0;
    p1_d = 1'b0;
    p2_d = 1'b0;
    case (state_q)
      SERVE_WAIT: begin
        x_d = X_W'(START_X);
        y_d = Y_W'(START_Y);
        cnt_d = launch ? '0 : cnt_q + SC_W'(tick);
        state_d = launch ? PLAY : SERVE_WAIT;
      end
      PLAY: if (tick) begin
        x_d = nx;
        y_d = ny;
        dir_x_d = ndx;
        dir_y_d = ndy;
        hit_d = c_hit;
        p1_d = c_p1;
        p2_d = c_p2;
        state_d = (c_p1 || c_p2) ? SCORED : PLAY;
        hits_d = c_hit ? (speedup ? '0 : hits_q + 1'b1) : hits_q;
        speed_d = (c_hit && speedup && speed_q != SPEED_W'(MAX_SPEED)) ? speed_q + 1'b1 : speed_q;
      end
      SCORED: begin
        // a miss leaves dir_y untouched, so it already points at the conceding player
        x_d = X_W'(START_X);
        y_d = Y_W'(START_Y);
        speed_d = SPEED_W'(1);
        hits_d = '0;
        state_d = SERVE_WAIT;
      end
      default: state_d = SERVE_WAIT;
    endcase
  end

  // State and ball registers with synchronous reset to the serve position.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SERVE_WAIT;
      x_q <= X_W'(START_X);
      y_q <= Y_W'(START_Y);
      dir_x_q <= 1'b0;
      dir_y_q <= 1'b1;
      speed_q <= SPEED_W'(1);
      hits_q <= '0;
      cnt_q <= '0;
      hit_q <= 1'b0;
      p1_q <= 1'b0;
      p2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      speed_q <= speed_d;
      hits_q <= hits_d;
      cnt_q <= cnt_d;
      hit_q <= hit_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;
  assign in_play = state_q == PLAY;
  assign hit = hit_q;
  assign point_p1 = p1_q;
  assign point_p2 = p2_q;
  assign speed = speed_q;
endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: directed play against a per-tick ball model plus hand-computed checkpoints
module tb_pong_ball_engine;
  logic clock = 1'b0;
  logic reset, tick, serve;
  logic [7:0] paddle_1_x, paddle_2_x, ball_x;
  logic [8:0] ball_y;
  logic in_play, hit, point_p1, point_p2;
  logic [2:0] speed;
  int tests = 0, fails = 0;
  int mx, my, vx, vy, msp, mhits, mstate, mcnt;
  bit mhit, mp1, mp2, armed = 1'b0;
  int nx, ny, px, c, nhits, n, k;
  bit over, contact;

  pong_ball_engine dut (
    .clock(clock), .reset(reset), .tick(tick), .serve(serve),
    .paddle_1_x(paddle_1_x), .paddle_2_x(paddle_2_x),
    .ball_x(ball_x), .ball_y(ball_y), .in_play(in_play), .hit(hit),
    .point_p1(point_p1), .point_p2(point_p2), .speed(speed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] trk(input int x);
    return x < 15 ? 8'd0 : 8'(x - 15);
  endfunction

  function automatic logic [7:0] away(input int x);
    return 8'((x + 128) % 256);
  endfunction

  // Model of the ball as position plus +/-1 velocity scaled by speed; states 0 wait, 1 play, 2 scored.
  task model_step();
    mhit = 0;
    mp1 = 0;
    mp2 = 0;
    if (reset) begin
      mx = 120; my = 160; vx = -1; vy = 1; msp = 1; mhits = 0; mstate = 0; mcnt = 0;
      armed = 1;
    end else if (mstate == 2) begin
      mx = 120; my = 160; msp = 1; mhits = 0; mstate = 0;
    end else if (mstate == 0) begin
      if (serve) begin
        mstate = 1; mcnt = 0;
      end else if (tick) begin
        mcnt++;
        if (mcnt == 60) begin mstate = 1; mcnt = 0; end
      end
    end else if (tick) begin
      nx = mx + vx * msp;
      ny = my + vy * msp;
      px = vy > 0 ? int'(paddle_2_x) : int'(paddle_1_x);
      over = (mx + 10 > px) && (mx < px + 41);
      contact = vy < 0 ? (my >= 35 && ny <= 35 && over) : (my + 10 <= 285 && ny + 10 >= 285 && over);
      c = mx + 5 - px;
      if (contact) begin
        mhit = 1;
        if (c < 13) vx = -1;
        else if (c >= 27) vx = 1;
        ny = vy < 0 ? 35 : 275;
        vy = -vy;
        mhits++;
        if (mhits == 4) begin
          mhits = 0;
          if (msp < 4) msp++;
        end
      end else if (vy < 0 && ny <= 30) begin
        ny = 30; mp2 = 1; mstate = 2;
      end else if (vy > 0 && ny >= 280) begin
        ny = 280; mp1 = 1; mstate = 2;
      end
      if (nx <= 0) begin nx = 0; vx = 1; end
      else if (nx >= 229) begin nx = 229; vx = -1; end
      mx = nx;
      my = ny;
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Every cycle after reset, all outputs must match the model.
  initial forever begin
    @(negedge clock);
    if (armed) begin
      chk("ball_x", ball_x, mx);
      chk("ball_y", ball_y, my);
      chk("speed", speed, msp);
      chk("in_play", in_play, mstate == 1);
      chk("hit", hit, mhit);
      chk("point_p1", point_p1, mp1);
      chk("point_p2", point_p2, mp2);
    end
  end

  task automatic tick_once();
    tick = 1;
    @(negedge clock);
    tick = 0;
  endtask

  task automatic track(input bit t1, input bit t2);
    paddle_1_x = t1 ? trk(mx) : away(mx);
    paddle_2_x = t2 ? trk(mx) : away(mx);
  endtask

  task automatic play_hits(input int target);
    n = 0;
    while (nhits < target && n < 4000) begin
      track(1, 1);
      tick_once();
      n++;
      if (mhit) nhits++;
      if (nhits < target && n % 3 == 0) @(negedge clock);
    end
    if (nhits < target) begin
      tests++; fails++;
      $display("FAIL play_hits: reached %0d hits, expected %0d", nhits, target);
    end
  endtask

  task automatic play_miss(input bit t1, input bit t2);
    n = 0;
    while (!(mp1 || mp2) && n < 4000) begin
      track(t1, t2);
      tick_once();
      n++;
    end
    if (!(mp1 || mp2)) begin
      tests++; fails++;
      $display("FAIL play_miss: no goal after %0d ticks, expected one", n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; tick = 0; serve = 0; paddle_1_x = 0; paddle_2_x = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    chk("rst_x", ball_x, 120);
    chk("rst_y", ball_y, 160);
    chk("rst_speed", speed, 1);
    chk("rst_in_play", in_play, 0);
    repeat (59) tick_once();
    chk("wait59_in_play", in_play, 0);
    tick_once();
    chk("wait60_in_play", in_play, 1);
    chk("wait60_x", ball_x, 120);
    chk("first_move_y_before", ball_y, 160);
    tick_once();
    chk("first_move_x", ball_x, 119);
    chk("first_move_y", ball_y, 161);
    k = 0;
    while (!mhit && k < 300) begin
      track(1, 1);
      tick_once();
      k++;
    end
    chk("first_hit_ticks", k, 114);
    chk("first_hit_pulse", hit, 1);
    chk("first_hit_x", ball_x, 5);
    chk("first_hit_y", ball_y, 275);
    nhits = 1;
    repeat (5) begin track(1, 1); tick_once(); end
    chk("wall_x", ball_x, 0);
    chk("wall_y", ball_y, 270);
    track(1, 1);
    tick_once();
    chk("wall_rebound_x", ball_x, 1);
    chk("wall_rebound_y", ball_y, 269);
    play_hits(3);
    chk("speed_at_3_hits", speed, 1);
    play_hits(4);
    chk("speed_at_4_hits", speed, 2);
    play_hits(12);
    chk("speed_at_12_hits", speed, 4);
    play_hits(28);
    chk("speed_at_28_hits", speed, 4);
    play_miss(1, 0);
    chk("p1_pulse", point_p1, 1);
    chk("p1_y", ball_y, 280);
    chk("p1_other", point_p2, 0);
    @(negedge clock);
    chk("p1_single", point_p1, 0);
    chk("scored_x", ball_x, 120);
    chk("scored_y", ball_y, 160);
    chk("scored_speed", speed, 1);
    chk("scored_in_play", in_play, 0);
    serve = 1; tick = 1;
    @(negedge clock);
    serve = 0; tick = 0;
    chk("serve_tick_in_play", in_play, 1);
    chk("serve_tick_x", ball_x, 120);
    chk("serve_tick_y", ball_y, 160);
    play_miss(0, 1);
    chk("p2_pulse", point_p2, 1);
    chk("p2_y", ball_y, 30);
    @(negedge clock);
    chk("p2_single", point_p2, 0);
    chk("p2_scored_y", ball_y, 160);
    serve = 1;
    @(negedge clock);
    serve = 0;
    chk("serve_in_play", in_play, 1);
    tick_once();
    chk("serve_dir_y", ball_y, 159);
    serve = 1;
    tick_once();
    serve = 0;
    chk("serve_ignored_in_play", in_play, 1);
    nhits = 0;
    play_hits(8);
    chk("speed_at_8_hits", speed, 3);
    track(1, 1);
    tick_once();
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("midplay_rst_x", ball_x, 120);
    chk("midplay_rst_y", ball_y, 160);
    chk("midplay_rst_speed", speed, 1);
    chk("midplay_rst_in_play", in_play, 0);
    chk("midplay_rst_hit", hit, 0);
    chk("midplay_rst_p1", point_p1, 0);
    chk("midplay_rst_p2", point_p2, 0);
    serve = 1;
    @(negedge clock);
    serve = 0;
    repeat (3) tick_once();
    chk("after_rst_x", ball_x, 117);
    chk("after_rst_y", ball_y, 163);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
